// File: rtl/decode_10b8b.sv
// 10b/8b decoder with running-disparity tracking and a saturating error count.
// Input code-group bit order is abcdei_fghj (a = bit 9, j = bit 0); output
// octet is HGFEDCBA (A = bit 0). One cycle of latency from input to output.
module decode_10b8b #(
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               code_group_10b,
    input  logic                     code_valid,
    input  logic                     err_count_clr,
    output logic [7:0]               code_group_8b,
    output logic                     is_control,
    output logic                     data_valid,
    output logic                     code_error,
    output logic                     disparity_error,
    output logic                     running_disparity,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic [5:0] sb6;
    logic [3:0] sb4;
    assign sb6 = code_group_10b[9:4];
    assign sb4 = code_group_10b[3:0];

    logic [4:0] edcba;
    logic       v6;
    logic       k28_6b;
    logic       kx7_6b;
    logic [2:0] hgf;
    logic       v4;
    logic       is_k;
    logic       cerr;
    logic       derr;
    logic [2:0] ones6;
    logic [2:0] ones4;
    logic       pos6, neg6, pos4, neg4;
    logic       rd6, rd4;

    logic [7:0]               code8_q, code8_d;
    logic                     is_k_q, is_k_d;
    logic                     dvalid_q, dvalid_d;
    logic                     cerr_q, cerr_d;
    logic                     derr_q, derr_d;
    logic                     rd_q, rd_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // 5b/6b sub-decoder: both RD columns map to the same EDCBA value.
    always_comb begin
        v6     = 1'b1;
        edcba  = 5'd0;
        k28_6b = 1'b0;
        kx7_6b = 1'b0;
        case (sb6)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: begin edcba = 5'd23; kx7_6b = 1'b1; end
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: begin edcba = 5'd27; kx7_6b = 1'b1; end
            6'b001110:            edcba = 5'd28;
            6'b001111, 6'b110000: begin edcba = 5'd28; k28_6b = 1'b1; end
            6'b101110, 6'b010001: begin edcba = 5'd29; kx7_6b = 1'b1; end
            6'b011110, 6'b100001: begin edcba = 5'd30; kx7_6b = 1'b1; end
            6'b101011, 6'b010100: edcba = 5'd31;
            default:              v6 = 1'b0;
        endcase
    end

    // 3b/4b sub-decoder; both x.P7 and x.A7 forms decode to 7.
    always_comb begin
        v4  = 1'b1;
        hgf = 3'd0;
        case (sb4)
            4'b1011, 4'b0100: hgf = 3'd0;
            4'b1001:          hgf = 3'd1;
            4'b0101:          hgf = 3'd2;
            4'b1100, 4'b0011: hgf = 3'd3;
            4'b1101, 4'b0010: hgf = 3'd4;
            4'b1010:          hgf = 3'd5;
            4'b0110:          hgf = 3'd6;
            4'b1110, 4'b0001,
            4'b0111, 4'b1000: hgf = 3'd7;
            default:          v4 = 1'b0;
        endcase
        // K28 only supports K28.5, whose 4b block is 1010/0101 (inverted vs data).
        if (k28_6b && (sb4 == 4'b1010 || sb4 == 4'b0101)) begin
            hgf = 3'd5;
        end
    end

    // Validity, K detection, sub-block disparity and the RD chain through the group.
    always_comb begin
        ones6 = 3'($countones(sb6));
        ones4 = 3'($countones(sb4));
        cerr  = !v6 || !v4 ||
                (k28_6b && !(sb4 == 4'b1010 || sb4 == 4'b0101));
        is_k  = k28_6b || (kx7_6b && (sb4 == 4'b0111 || sb4 == 4'b1000));
        pos6  = (ones6 > 3'd3) || (sb6 == 6'b000111);
        neg6  = (ones6 < 3'd3) || (sb6 == 6'b111000);
        pos4  = (ones4 > 3'd2) || (sb4 == 4'b0011);
        neg4  = (ones4 < 3'd2) || (sb4 == 4'b1100);
        rd6   = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_q);
        rd4   = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd6);
        derr  = !cerr && ((pos6 && rd_q) || (neg6 && !rd_q) ||
                          (pos4 && rd6)  || (neg4 && !rd6));
    end

    // Next-state for output registers, RD and the saturating error counter.
    always_comb begin
        code8_d   = code8_q;
        is_k_d    = is_k_q;
        dvalid_d  = 1'b0;
        cerr_d    = cerr_q;
        derr_d    = derr_q;
        rd_d      = rd_q;
        err_cnt_d = err_cnt_q;
        if (code_valid) begin
            dvalid_d = 1'b1;
            code8_d  = cerr ? 8'h00 : {hgf, edcba};
            is_k_d   = !cerr && is_k;
            cerr_d   = cerr;
            derr_d   = derr;
            rd_d     = rd4;
        end
        if (err_count_clr) begin
            err_cnt_d = '0;
        end else if (code_valid && (cerr || derr) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // State registers; reset clears everything and returns RD to negative.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code8_q   <= 8'h00;
            is_k_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            cerr_q    <= 1'b0;
            derr_q    <= 1'b0;
            rd_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            code8_q   <= code8_d;
            is_k_q    <= is_k_d;
            dvalid_q  <= dvalid_d;
            cerr_q    <= cerr_d;
            derr_q    <= derr_d;
            rd_q      <= rd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign code_group_8b     = code8_q;
    assign is_control        = is_k_q;
    assign data_valid        = dvalid_q;
    assign code_error        = cerr_q;
    assign disparity_error   = derr_q;
    assign running_disparity = rd_q;
    assign err_count         = err_cnt_q;

endmodule
